tag_release_queue: RTL

In-order multi-port release queue that feeds the write (free) side of the tag freelist. Tags granted by the freelist read ports are pushed here in allocation order. When the owning instructions complete, the same tags are popped oldest-first and driven as `we_`/`wd` into the freelist write ports. This is the return path that closes the allocate/free loop, and it supports a pipeline flush.

---
 rtl/tag_release_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/tag_release_queue.sv
// In-order release queue returning granted tags to the freelist write ports.
// Multi-lane compacting push, oldest-first multi-lane release, and flush.
module tag_release_queue #(
    parameter int DEPTH = 16,
    parameter int DATA  = 4,
    parameter int IN    = 4,
    parameter int OUT   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_,
    input  logic [IN-1:0]              push_,
    input  logic [IN*DATA-1:0]         pd,
    input  logic [$clog2(OUT):0]       rel_num,
    output logic [OUT-1:0]             we_,
    output logic [OUT*DATA-1:0]        wd,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int NPW  = $clog2(IN) + 1;

    logic [DATA-1:0] mem [DEPTH];
    logic [PW-1:0]   hp_reg;
    logic [PW-1:0]   tp_reg;

    logic [IN-1:0]   en;
    logic [NPW-1:0]  npush;
    logic [NPW-1:0]  off [IN];
    logic [CNTW-1:0] nrel;
    logic            accept;

    assign en    = ~push_;
    assign full  = (CNTW'(DEPTH) - count) < CNTW'(IN);
    assign empty = (count == '0);

    // Each enabled lane's slot offset is the number of enabled lanes below it.
    always_comb begin
        npush = '0;
        for (int i = 0; i < IN; i++) begin
            off[i] = npush;
            npush  = npush + NPW'(en[i]);
        end
        nrel = CNTW'(rel_num);
        if (nrel > CNTW'(OUT)) nrel = CNTW'(OUT);
        if (nrel > count)      nrel = count;
    end

    assign accept = (npush != '0) && !full;

    always_ff @(posedge clk) begin
        if (!reset && flush_ && accept) begin
            for (int i = 0; i < IN; i++) begin
                if (en[i]) mem[tp_reg + PW'(off[i])] <= pd[i*DATA +: DATA];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hp_reg <= '0;
            tp_reg <= '0;
            count  <= '0;
            we_    <= '1;
            wd     <= '0;
            ovf    <= 1'b0;
        end else if (!flush_) begin
            hp_reg <= '0;
            tp_reg <= '0;
            count  <= '0;
            we_    <= '1;
            wd     <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) tp_reg <= tp_reg + PW'(npush);
            hp_reg <= hp_reg + PW'(nrel);
            count  <= count + (accept ? CNTW'(npush) : CNTW'(0)) - nrel;
            ovf    <= (npush != '0) && full;
            for (int i = 0; i < OUT; i++) begin
                if (CNTW'(i) < nrel) begin
                    we_[i]               <= 1'b0;
                    wd[i*DATA +: DATA]   <= mem[hp_reg + PW'(i)];
                end else begin
                    we_[i]               <= 1'b1;
                    wd[i*DATA +: DATA]   <= '0;
                end
            end
        end
    end
endmodule
